// File: rtl/membus_arb.sv
// membus_arb: shares one membus port between two masters, granting one whole memory cycle at a time.
// Build option MEMBUS_ARB_RR_EN: round-robin tie-break (default: master 0 always wins ties).
module membus_arb #(
  parameter int unsigned ma_w = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_rq_cyc,
  input  logic              m0_rd_rq,
  input  logic              m0_wr_rq,
  input  logic              m0_wr_rs,
  input  logic              m0_fmc_select,
  input  logic [36-ma_w:35] m0_ma,
  input  logic [0:35]       m0_mb_out,
  output logic              m0_addr_ack,
  output logic              m0_rd_rs,
  output logic [0:35]       m0_mb_in,
  input  logic              m1_rq_cyc,
  input  logic              m1_rd_rq,
  input  logic              m1_wr_rq,
  input  logic              m1_wr_rs,
  input  logic              m1_fmc_select,
  input  logic [36-ma_w:35] m1_ma,
  input  logic [0:35]       m1_mb_out,
  output logic              m1_addr_ack,
  output logic              m1_rd_rs,
  output logic [0:35]       m1_mb_in,
  output logic              membus_rq_cyc,
  output logic              membus_rd_rq,
  output logic              membus_wr_rq,
  output logic              membus_wr_rs,
  output logic              membus_fmc_select,
  output logic [36-ma_w:35] membus_ma,
  output logic [0:35]       membus_mb_out,
  input  logic              membus_addr_ack,
  input  logic              membus_rd_rs,
  input  logic [0:35]       membus_mb_in
);
  localparam int unsigned MA_LO = 36 - ma_w;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT_RS, GAP} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             wr_op_q, wr_op_d;
  logic             any_rq, winner;
  logic             sel_rq_cyc, sel_rd_rq, sel_wr_rq, sel_wr_rs, sel_fmc;
  logic [MA_LO:35]  sel_ma;
  logic [0:35]      sel_mb_out;
  logic             ack_fwd, rd_fwd, mb_in_en;

  // Request lines of whichever master currently holds the grant
  always_comb begin
    sel_rq_cyc = gnt_q ? m1_rq_cyc     : m0_rq_cyc;
    sel_rd_rq  = gnt_q ? m1_rd_rq      : m0_rd_rq;
    sel_wr_rq  = gnt_q ? m1_wr_rq      : m0_wr_rq;
    sel_wr_rs  = gnt_q ? m1_wr_rs      : m0_wr_rs;
    sel_fmc    = gnt_q ? m1_fmc_select : m0_fmc_select;
    sel_ma     = gnt_q ? m1_ma         : m0_ma;
    sel_mb_out = gnt_q ? m1_mb_out     : m0_mb_out;
  end

  assign any_rq = m0_rq_cyc | m1_rq_cyc;

`ifdef MEMBUS_ARB_RR_EN
  logic last_q;

  // Last-granted master; resets to 1 so master 0 takes the first tie
  always_ff @(posedge clk) begin
    if (reset)
      last_q <= 1'b1;
    else if (state_q == IDLE && any_rq)
      last_q <= winner;
  end

  assign winner = (m0_rq_cyc && m1_rq_cyc) ? ~last_q : ~m0_rq_cyc;
`else
  assign winner = ~m0_rq_cyc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      wr_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_op_q <= wr_op_d;
    end
  end

  // Next state, bus steering and pulse routing
  always_comb begin
    state_d           = state_q;
    gnt_d             = gnt_q;
    wr_op_d           = wr_op_q;
    ack_fwd           = 1'b0;
    rd_fwd            = 1'b0;
    mb_in_en          = 1'b0;
    membus_rq_cyc     = 1'b0;
    membus_rd_rq      = 1'b0;
    membus_wr_rq      = 1'b0;
    membus_wr_rs      = 1'b0;
    membus_fmc_select = 1'b0;
    membus_ma         = '0;
    membus_mb_out     = '0;

    case (state_q)
      IDLE: begin
        if (any_rq) begin
          gnt_d   = winner;
          state_d = ADDR;
        end
      end
      ADDR: begin
        membus_rq_cyc     = sel_rq_cyc;
        membus_rd_rq      = sel_rd_rq;
        membus_wr_rq      = sel_wr_rq;
        membus_fmc_select = sel_fmc;
        membus_ma         = sel_ma;
        membus_mb_out     = sel_mb_out;
        mb_in_en          = 1'b1;
        if (membus_addr_ack) begin
          ack_fwd = 1'b1;
          rd_fwd  = membus_rd_rs;
          wr_op_d = sel_wr_rq;
          // A read whose restart arrives with the ack is already complete
          state_d = (!sel_wr_rq && membus_rd_rs) ? GAP : WAIT_RS;
        end else if (!sel_rq_cyc) begin
          state_d = GAP;
        end
      end
      WAIT_RS: begin
        membus_mb_out = sel_mb_out;
        mb_in_en      = 1'b1;
        rd_fwd        = membus_rd_rs;
        if (wr_op_q) begin
          membus_wr_rs = sel_wr_rs;
          if (sel_wr_rs)
            state_d = GAP;
        end else if (membus_rd_rs) begin
          state_d = GAP;
        end
      end
      GAP: begin
        mb_in_en = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    m0_addr_ack = ack_fwd & ~gnt_q;
    m1_addr_ack = ack_fwd &  gnt_q;
    m0_rd_rs    = rd_fwd  & ~gnt_q;
    m1_rd_rs    = rd_fwd  &  gnt_q;
    m0_mb_in    = (mb_in_en && !gnt_q) ? membus_mb_in : '0;
    m1_mb_in    = (mb_in_en &&  gnt_q) ? membus_mb_in : '0;
  end

endmodule
